// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive sequencer. Tracks start/data/parity/stop bits with an
// oversampling edge counter, pulses the checker/deserializer enables and reports frame status.
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 5
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RX_IN,
    input  logic               PAR_EN,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               strt_glitch,
    input  logic               par_err,
    input  logic               stp_err,
    output logic [PRESC_W-1:0] edge_cnt,
    output logic [3:0]         bit_cnt,
    output logic               dat_samp_en,
    output logic               deser_en,
    output logic               strt_chk_en,
    output logic               par_chk_en,
    output logic               stp_chk_en,
    output logic               data_valid,
    output logic               frame_err
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t             state, state_nxt;
    logic [PRESC_W-1:0] p_lat;
    logic               err;
    logic               last;
    assign last = edge_cnt == p_lat - PRESC_W'(1);
    always_comb begin
        state_nxt   = state;
        strt_chk_en = 1'b0;
        deser_en    = 1'b0;
        par_chk_en  = 1'b0;
        stp_chk_en  = 1'b0;
        case (state)
            IDLE:   state_nxt = RX_IN ? IDLE : START;
            START:  if (last) begin
                        strt_chk_en = 1'b1;
                        state_nxt   = strt_glitch ? IDLE : DATA;
                    end
            DATA:   if (last) begin
                        deser_en = 1'b1;
                        if (bit_cnt == 4'(DATA_WIDTH))
                            state_nxt = PAR_EN ? PARITY : STOP;
                    end
            PARITY: if (last) begin
                        par_chk_en = 1'b1;
                        state_nxt  = STOP;
                    end
            STOP:   if (last) begin
                        stp_chk_en = 1'b1;
                        state_nxt  = IDLE;
                    end
            default: state_nxt = IDLE;
        endcase
    end
    // Prescale is re-latched every IDLE cycle, so the value seen on the start edge holds for the frame.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state       <= IDLE;
            edge_cnt    <= '0;
            bit_cnt     <= '0;
            p_lat       <= PRESC_W'(8);
            err         <= 1'b0;
            dat_samp_en <= 1'b0;
            data_valid  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state       <= state_nxt;
            dat_samp_en <= state_nxt != IDLE;
            data_valid  <= stp_chk_en && !(err || stp_err);
            frame_err   <= stp_chk_en && (err || stp_err);
            if (state == IDLE) begin
                edge_cnt <= '0;
                bit_cnt  <= '0;
                p_lat    <= (prescale == PRESC_W'(16)) ? PRESC_W'(16) : PRESC_W'(8);
            end else if (state_nxt == IDLE) begin
                edge_cnt <= '0;
                bit_cnt  <= '0;
            end else if (last) begin
                edge_cnt <= '0;
                bit_cnt  <= bit_cnt + 4'd1;
            end else begin
                edge_cnt <= edge_cnt + PRESC_W'(1);
            end
            if (stp_chk_en)
                err <= 1'b0;
            else if (par_chk_en)
                err <= err || par_err;
        end
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed frames against a frame-position model of the receive sequencer,
// checked every cycle, plus literal frame-timing and pulse-count expectations.
module tb_uart_rx_ctrl;
    localparam int DW = 8;
    logic       CLK = 0, RST = 0, RX_IN = 1, PAR_EN = 0;
    logic [4:0] prescale = 5'd8;
    logic       strt_glitch = 0, par_err = 0, stp_err = 0;
    logic [4:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid, frame_err;

    uart_rx_ctrl #(.DATA_WIDTH(DW), .PRESC_W(5)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .prescale(prescale),
        .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
        .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .dat_samp_en(dat_samp_en), .deser_en(deser_en),
        .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en),
        .data_valid(data_valid), .frame_err(frame_err)
    );

    always #5 CLK = ~CLK;
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int tests = 0, fails = 0;
    int n_deser, n_strt, n_par, n_dv, n_fe, fe_cyc, fall;
    int dv_q[$];
    // Model: position r (1-based cycle count since the detected start), latched p, parity flag.
    bit m_act = 0, m_par = 0, m_err = 0, m_dv = 0, m_fe = 0, armed = 0;
    int m_r = 0, m_p = 8;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", n, cyc, a, e);
        end
    endtask

    always @(negedge CLK) begin
        int e_edge, e_bit, e_end;
        bit e_samp, e_strt, e_des, e_par, e_stp;
        if (armed) begin
            e_edge = 0; e_bit = 0; e_samp = 0; e_strt = 0; e_des = 0; e_par = 0; e_stp = 0;
            if (m_act) begin
                e_end  = (DW + 2 + int'(m_par)) * m_p;
                e_edge = (m_r - 1) % m_p;
                e_bit  = (m_r - 1) / m_p;
                e_samp = 1;
                e_strt = m_r == m_p;
                e_des  = (m_r % m_p == 0) && (m_r / m_p >= 2) && (m_r / m_p <= DW + 1);
                e_par  = m_par && m_r == (DW + 2) * m_p;
                e_stp  = m_r == e_end;
            end
            chk("edge_cnt", edge_cnt, e_edge);
            chk("bit_cnt", bit_cnt, e_bit);
            chk("dat_samp_en", dat_samp_en, e_samp);
            chk("strt_chk_en", strt_chk_en, e_strt);
            chk("deser_en", deser_en, e_des);
            chk("par_chk_en", par_chk_en, e_par);
            chk("stp_chk_en", stp_chk_en, e_stp);
            chk("data_valid", data_valid, m_dv);
            chk("frame_err", frame_err, m_fe);
            if (deser_en === 1'b1) n_deser++;
            if (strt_chk_en === 1'b1) n_strt++;
            if (par_chk_en === 1'b1) n_par++;
            if (data_valid === 1'b1) begin n_dv++; dv_q.push_back(cyc); end
            if (frame_err === 1'b1) begin n_fe++; fe_cyc = cyc; end
        end
        if (!RST) begin
            m_act = 0; m_dv = 0; m_fe = 0; m_err = 0; armed = 1;
        end else if (armed) begin
            m_dv = 0; m_fe = 0;
            if (m_act) begin
                if (m_r == m_p && strt_glitch) m_act = 0;
                else begin
                    if (m_r == (DW + 1) * m_p) m_par = PAR_EN;
                    if (m_par && m_r == (DW + 2) * m_p) m_err = m_err | par_err;
                    if (m_r == (DW + 2 + int'(m_par)) * m_p) begin
                        m_dv = !(m_err | stp_err); m_fe = m_err | stp_err; m_err = 0; m_act = 0;
                    end else m_r++;
                end
            end else if (!RX_IN) begin
                m_act = 1; m_r = 1; m_p = (prescale == 5'd16) ? 16 : 8; m_par = 0; m_err = 0;
            end
        end
    end

    task automatic clr();
        n_deser = 0; n_strt = 0; n_par = 0; n_dv = 0; n_fe = 0; fe_cyc = -1; dv_q.delete();
    endtask

    task automatic idle(input int n);
        RX_IN = 1;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input int p, input bit par, input int rst_at, input int chg_at);
        int b;
        PAR_EN = par;
        for (int i = 0; i < (10 + int'(par)) * p; i++) begin
            @(posedge CLK); #1;
            b = i / p;
            if (i == 0) fall = cyc;
            RX_IN = (b == 0) ? 1'b0 : (b <= 8) ? d[b-1] : (par && b == 9) ? ^d : 1'b1;
            if (i == chg_at) prescale = 5'd16;
            if (i == rst_at) begin
                RST = 0; RX_IN = 1;
                @(posedge CLK); #1;
                RST = 1;
                return;
            end
        end
    endtask

    function automatic int dv_at(input int k, input int base);
        return (dv_q.size() > k) ? dv_q[k] - base : -1;
    endfunction

    initial begin
        int f1;
        clr();
        repeat (3) @(posedge CLK);
        #1 RST = 1;
        @(negedge CLK);
        chk("reset_data_valid", data_valid, 0);
        chk("reset_edge_cnt", edge_cnt, 0);
        idle(4);
        // p=8, no parity, 0xA5
        clr(); send(8'hA5, 8, 0, -1, -1); idle(12);
        chk("t1_dv_count", n_dv, 1);
        chk("t1_dv_latency", dv_at(0, fall), 81);
        chk("t1_deser_count", n_deser, 8);
        chk("t1_fe_count", n_fe, 0);
        // p=8, parity error
        par_err = 1;
        clr(); send(8'h96, 8, 1, -1, -1); idle(12);
        par_err = 0;
        chk("t2_dv_count", n_dv, 0);
        chk("t2_fe_count", n_fe, 1);
        chk("t2_par_count", n_par, 1);
        chk("t2_fe_latency", fe_cyc - fall, 89);
        // start glitch
        strt_glitch = 1;
        clr();
        @(posedge CLK); #1 RX_IN = 0; fall = cyc;
        repeat (2) @(posedge CLK);
        #1 RX_IN = 1;
        idle(12);
        strt_glitch = 0;
        chk("t3_strt_count", n_strt, 1);
        chk("t3_deser_count", n_deser, 0);
        chk("t3_dv_count", n_dv, 0);
        @(negedge CLK);
        chk("t3_edge_zero", edge_cnt, 0);
        chk("t3_bit_zero", bit_cnt, 0);
        // p=16, 0x3C
        prescale = 5'd16;
        clr(); send(8'h3C, 16, 0, -1, -1); idle(20);
        chk("t4_dv_latency", dv_at(0, fall), 161);
        chk("t4_deser_count", n_deser, 8);
        // reset mid-frame at DATA bit 4, then a clean frame
        prescale = 5'd8;
        clr(); send(8'h81, 8, 0, 36, -1); idle(20);
        chk("t5_abort_dv", n_dv, 0);
        chk("t5_abort_fe", n_fe, 0);
        clr(); send(8'h5A, 8, 0, -1, -1); idle(12);
        chk("t5_dv_count", n_dv, 1);
        chk("t5_dv_latency", dv_at(0, fall), 81);
        // back-to-back frames, prescale changed mid first frame
        clr(); send(8'h55, 8, 0, -1, 20); f1 = fall;
        send(8'hF0, 16, 0, -1, -1); idle(24);
        chk("t6_dv_count", n_dv, 2);
        chk("t6_dv1_latency", dv_at(0, f1), 81);
        chk("t6_dv2_latency", dv_at(1, f1), 242);
        // illegal prescale behaves as 8
        prescale = 5'd5;
        clr(); send(8'hC3, 8, 0, -1, -1); idle(12);
        chk("t7_dv_latency", dv_at(0, fall), 81);
        chk("t7_deser_count", n_deser, 8);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
